// File: rtl/v2_filter_ctrl_pkg.sv
// Package: v2_ctrl_pkg
// Shared types and default widths for the V2 trapezoidal filter sequencer.
//   state_t  : sequencer states
//   result_t : captured pulse result {peak, ts}
package v2_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_KL_W  = 6;
  localparam int unsigned DEF_M_W   = 8;
  localparam int unsigned DEF_TS_W  = 32;
  localparam int unsigned BL_SHIFT  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_ARMED,
    S_CAPTURE,
    S_HOLDOFF
  } state_t;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] peak;
    logic [DEF_TS_W-1:0]         ts;
  } result_t;

endpackage

// File: rtl/v2_filter_ctrl_peak_capture.sv
// Module: v2_peak_capture
// Tracks peak amplitude/timestamp of one pulse and counts CAPTURE cycles.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_clear      : zero peak, timestamp and window count
//   i_start      : load first above-threshold sample and its timestamp
//   i_update     : one CAPTURE cycle; keep the first strict maximum
//   i_sample     : signed sample; i_ts : current timestamp
//   o_peak/o_ts  : tracked peak and its timestamp
//   o_win_last   : current CAPTURE cycle is the last one allowed
module v2_peak_capture
  import v2_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TS_W    = DEF_TS_W,
  parameter int unsigned MAX_WIN = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_start,
  input  logic                    i_update,
  input  logic signed [WIDTH-1:0] i_sample,
  input  logic [TS_W-1:0]         i_ts,
  output logic signed [WIDTH-1:0] o_peak,
  output logic [TS_W-1:0]         o_ts,
  output logic                    o_win_last
);

  localparam int unsigned WIN_W = $clog2(MAX_WIN + 1);

  logic signed [WIDTH-1:0] r_peak;
  logic [TS_W-1:0]         r_ts;
  logic [WIN_W-1:0]        r_win;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_peak <= '0;
      r_ts   <= '0;
      r_win  <= '0;
    end else if (i_start) begin
      r_peak <= i_sample;
      r_ts   <= i_ts;
      r_win  <= '0;
    end else if (i_update) begin
      if (i_sample > r_peak) begin
        r_peak <= i_sample;
        r_ts   <= i_ts;
      end
      if (!o_win_last) r_win <= r_win + 1'b1;
    end
  end

  assign o_peak     = r_peak;
  assign o_ts       = r_ts;
  assign o_win_last = (r_win == WIN_W'(MAX_WIN - 1));

endmodule

// File: rtl/v2_filter_ctrl.sv
// Module: v2_filter_ctrl
// Sequencer for the V2 trapezoidal shaping filter: latches config, flushes the
// filter delay line, arms a threshold trigger, captures peak/timestamp per pulse
// and presents results over valid/ready.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   enable                     : run request; low forces IDLE
//   cfg_valid/cfg_ready        : config handshake (ready only in IDLE)
//   cfg_k/l/m, cfg_thr         : shaping config and signed trigger threshold
//   filt_run                   : 1 = filter running, 0 = held clear
//   filt_k/l/m                 : latched config driven to the filter
//   filt_out                   : signed shaped filter output
//   res_valid/res_ready        : result handshake; res_peak, res_ts result data
//   ovf_cnt                    : dropped results, saturating
//   cfg_err                    : sticky bad-config flag; busy : state != IDLE
// Build option: V2_CTRL_BASELINE_EN enables an EMA baseline restorer; trigger
// and peak then use (filt_out - baseline), saturated.
module v2_filter_ctrl
  import v2_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned KL_W     = DEF_KL_W,
  parameter int unsigned M_W      = DEF_M_W,
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned HOLDOFF  = 8,
  parameter int unsigned MAX_WIN  = 64,
  parameter int unsigned TS_W     = DEF_TS_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [KL_W-1:0]         cfg_k,
  input  logic [KL_W-1:0]         cfg_l,
  input  logic [M_W-1:0]          cfg_m,
  input  logic signed [WIDTH-1:0] cfg_thr,
  output logic                    filt_run,
  output logic [KL_W-1:0]         filt_k,
  output logic [KL_W-1:0]         filt_l,
  output logic [M_W-1:0]          filt_m,
  input  logic signed [WIDTH-1:0] filt_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] res_peak,
  output logic [TS_W-1:0]         res_ts,
  output logic [15:0]             ovf_cnt,
  output logic                    cfg_err,
  output logic                    busy
);

  state_t                  r_state, w_next;
  logic [KL_W-1:0]         r_k, r_l;
  logic [M_W-1:0]          r_m;
  logic signed [WIDTH-1:0] r_thr;
  logic                    r_cfg_ok, r_cfg_err;
  logic [KL_W+1:0]         r_cnt;
  logic [TS_W-1:0]         r_ts;
  logic                    r_emit;
  result_t                 r_res;
  logic                    r_res_valid;
  logic [15:0]             r_ovf;

  logic                    w_cfg_hs, w_cfg_bad, w_start_flush;
  logic                    w_pk_start, w_pk_update, w_exit, w_win_last;
  logic [KL_W+1:0]         w_flush_last;
  logic signed [WIDTH-1:0] w_sample, w_pk_peak;
  logic [TS_W-1:0]         w_pk_ts;

  assign w_cfg_hs     = cfg_valid && cfg_ready;
  assign w_cfg_bad    = (cfg_l == '0) || (cfg_k < cfg_l);
  assign w_flush_last = (KL_W+2)'(r_k) + (KL_W+2)'(r_l) + (KL_W+2)'(PIPE_LAT - 1);
  assign w_start_flush = (r_state == S_IDLE) && (w_next == S_FLUSH);

`ifdef V2_CTRL_BASELINE_EN
  logic signed [WIDTH-1:0] r_bl;
  logic signed [WIDTH:0]   w_raw, w_bl_step;

  assign w_raw     = {filt_out[WIDTH-1], filt_out} - {r_bl[WIDTH-1], r_bl};
  assign w_bl_step = w_raw >>> BL_SHIFT;

  always_comb begin
    w_sample = w_raw[WIDTH-1:0];
    if (w_raw[WIDTH] != w_raw[WIDTH-1]) begin
      w_sample = w_raw[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_start_flush) r_bl <= '0;
    else if (r_state == S_ARMED) r_bl <= r_bl + w_bl_step[WIDTH-1:0];
  end
`else
  assign w_sample = filt_out;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pk_start  = 1'b0;
    w_pk_update = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      S_IDLE:    if (enable && r_cfg_ok && !w_cfg_hs) w_next = S_FLUSH;
      S_FLUSH:   if (r_cnt == w_flush_last) w_next = S_ARMED;
      S_ARMED: begin
        if (w_sample > r_thr) begin
          w_next     = S_CAPTURE;
          w_pk_start = 1'b1;
        end
      end
      S_CAPTURE: begin
        w_pk_update = 1'b1;
        if ((w_sample <= r_thr) || w_win_last) begin
          w_next = S_HOLDOFF;
          w_exit = 1'b1;
        end
      end
      S_HOLDOFF: if (r_cnt == (KL_W+2)'(HOLDOFF - 1)) w_next = S_ARMED;
      default:   w_next = S_IDLE;
    endcase
    // Dropping enable aborts everything, including a capture exiting this cycle.
    if (!enable) begin
      w_next = S_IDLE;
      w_exit = 1'b0;
    end
  end

  // Cycles spent in the current state; FLUSH and HOLDOFF lengths use it.
  always_ff @(posedge clk) begin
    if (reset || (w_next != r_state)) r_cnt <= '0;
    else                              r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k       <= '0;
      r_l       <= '0;
      r_m       <= '0;
      r_thr     <= '0;
      r_cfg_ok  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (w_cfg_hs) begin
      if (w_cfg_bad) begin
        r_cfg_err <= 1'b1;
      end else begin
        r_k       <= cfg_k;
        r_l       <= cfg_l;
        r_m       <= cfg_m;
        r_thr     <= cfg_thr;
        r_cfg_ok  <= 1'b1;
        r_cfg_err <= 1'b0;
      end
    end
  end

  v2_peak_capture #(
    .WIDTH   (WIDTH),
    .TS_W    (TS_W),
    .MAX_WIN (MAX_WIN)
  ) u_peak (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_start_flush),
    .i_start    (w_pk_start),
    .i_update   (w_pk_update),
    .i_sample   (w_sample),
    .i_ts       (r_ts),
    .o_peak     (w_pk_peak),
    .o_ts       (w_pk_ts),
    .o_win_last (w_win_last)
  );

  // The exit decision is registered so the result register loads the settled
  // peak one cycle later, after the final CAPTURE update has landed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_emit      <= 1'b0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_ovf       <= '0;
    end else begin
      r_emit <= w_exit;
      if (r_emit) begin
        if (r_res_valid && !res_ready) begin
          if (r_ovf != '1) r_ovf <= r_ovf + 1'b1;
        end else begin
          r_res       <= '{peak: w_pk_peak, ts: w_pk_ts};
          r_res_valid <= 1'b1;
        end
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign cfg_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign filt_run  = (r_state != S_IDLE);
  assign filt_k    = r_k;
  assign filt_l    = r_l;
  assign filt_m    = r_m;
  assign cfg_err   = r_cfg_err;
  assign res_valid = r_res_valid;
  assign res_peak  = r_res.peak;
  assign res_ts    = r_res.ts;
  assign ovf_cnt   = r_ovf;

endmodule
